// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D main-memory port arbiter.
// State and owner encodings plus beat-index width derivation.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic int beat_w(input int lw);
        return (lw > 1) ? $clog2(lw) : 1;
    endfunction

endpackage

// File: rtl/mem_port_rr_pick.sv
// Two-input round-robin picker for the memory port arbiter.
// On a tie the side that did not own the last burst wins.
module mem_port_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (i_req && d_req) begin
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Line-burst arbiter sharing main memory between I and D refill sides.
// Optional perf counters: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    localparam int BEAT_W     = beat_w(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [BEAT_W-1:0] i_beat,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [BEAT_W-1:0] d_beat,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       perf_grants_i,
    output logic [31:0]       perf_grants_d,
    output logic [31:0]       perf_wait
);

    localparam int OFF_BITS = $clog2(LINE_WORDS) + 2;
    localparam logic [ADDR_W-1:0] OFF_MASK =
        ADDR_W'((64'd1 << OFF_BITS) - 64'd1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LINE_WORDS - 1);

    state_t            state;
    state_t            state_d;
    owner_t            owner;
    owner_t            last_owner;
    owner_t            grant_owner;
    logic              grant_valid;
    logic              we_r;
    logic [ADDR_W-1:0] base_r;
    logic [BEAT_W-1:0] beat;
    logic              grant;
    logic              beat_ack;
    logic              last_beat;
    logic              owner_i;
    logic              owner_d;
    logic              rd_ack;

    mem_port_rr_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant     = (state == IDLE) && grant_valid;
    assign beat_ack  = (state == BURST) && mem_ack;
    assign last_beat = (beat == LAST);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (grant_valid) state_d = BURST;
            BURST:   if (mem_ack && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner      <= OWN_I;
            last_owner <= OWN_D;
            we_r       <= 1'b0;
            base_r     <= '0;
            beat       <= '0;
        end else begin
            if (grant) begin
                owner  <= grant_owner;
                we_r   <= (grant_owner == OWN_D) && d_we;
                base_r <= ((grant_owner == OWN_D) ? d_addr : i_addr)
                          & ~OFF_MASK;
                beat   <= '0;
            end
            if (beat_ack && !last_beat) begin
                beat <= beat + BEAT_W'(1);
            end
            // beat only returns to zero on the way out of a burst
            if (state == DONE) begin
                last_owner <= owner;
                beat       <= '0;
            end
        end
    end

    assign owner_i = (state != IDLE) && (owner == OWN_I);
    assign owner_d = (state != IDLE) && (owner == OWN_D);
    assign rd_ack  = beat_ack && !we_r;

    assign mem_req   = (state == BURST);
    assign mem_we    = mem_req && we_r;
    assign mem_addr  = base_r + ADDR_W'(beat) * STRIDE;
    assign mem_wdata = mem_we ? d_wdata : '0;
    assign rdata     = mem_rdata;

    assign i_rvalid = rd_ack && (owner == OWN_I);
    assign d_rvalid = rd_ack && (owner == OWN_D);
    assign i_beat   = owner_i ? beat : '0;
    assign d_beat   = owner_d ? beat : '0;
    assign i_done   = (state == DONE) && (owner == OWN_I);
    assign d_done   = (state == DONE) && (owner == OWN_D);

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] cnt_gi;
    logic [31:0] cnt_gd;
    logic [31:0] cnt_wait;
    logic        waiting;

    assign waiting = (i_req && !owner_i) || (d_req && !owner_d);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_gi   <= '0;
            cnt_gd   <= '0;
            cnt_wait <= '0;
        end else begin
            if (grant && grant_owner == OWN_I) cnt_gi <= cnt_gi + 32'd1;
            if (grant && grant_owner == OWN_D) cnt_gd <= cnt_gd + 32'd1;
            if (waiting) cnt_wait <= cnt_wait + 32'd1;
        end
    end

    assign perf_grants_i = cnt_gi;
    assign perf_grants_d = cnt_gd;
    assign perf_wait     = cnt_wait;
`else
    assign perf_grants_i = '0;
    assign perf_grants_d = '0;
    assign perf_wait     = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory.
// Expected beats, read returns and done pulses are queued at stimulus time.
module tb_mem_port_arbiter;

    localparam int LW = 4;
    localparam logic [31:0] RKEY = 32'hDEAD_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic        side;
        int          beat;
        logic [31:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rvalid;
    logic [1:0]  i_beat;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic [1:0]  d_beat;
    logic        d_done;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] perf_grants_i;
    logic [31:0] perf_grants_d;
    logic [31:0] perf_wait;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 0;
    int mcnt = 0;
    logic spur = 1'b0;
    int req_cyc = -1;
    int exp_gap = 0;
    logic chk_len = 1'b1;
    int last_ack_cyc = 0;
    int hicnt = 0;
    int locnt = 0;
    logic prev_req = 1'b0;

    mexp_t mq[$];
    rexp_t rq[$];
    logic  dq[$];

    assign d_wdata = 32'hA0 + 32'(d_beat);

    mem_port_arbiter dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_rvalid      (i_rvalid),
        .i_beat        (i_beat),
        .i_done        (i_done),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_rvalid      (d_rvalid),
        .d_beat        (d_beat),
        .d_done        (d_done),
        .rdata         (rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .perf_grants_i (perf_grants_i),
        .perf_grants_d (perf_grants_d),
        .perf_wait     (perf_wait)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // memory: ack arrives lat cycles after mem_req, held to one posedge
    always @(negedge clk) begin
        mem_rdata = mem_addr ^ RKEY;
        if (mem_req) begin
            if (mcnt >= lat) begin
                mem_ack = 1'b1;
                mcnt = 0;
            end else begin
                mem_ack = 1'b0;
                mcnt = mcnt + 1;
            end
        end else begin
            mem_ack = spur;
            mcnt = 0;
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (mem_req && mem_ack) begin
            if (mq.size() == 0) begin
                check("mem_unexp", mq.size(), 1);
            end else begin
                mexp_t e;
                e = mq.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_we", mem_we, e.we);
                check("mem_wdata", mem_wdata, e.wdata);
            end
            last_ack_cyc = cyc;
        end
        if (i_rvalid || d_rvalid) begin
            check("rv_both", i_rvalid && d_rvalid, 0);
            check("rv_ack", mem_ack && mem_req, 1);
            if (rq.size() == 0) begin
                check("rv_unexp", rq.size(), 1);
            end else begin
                rexp_t r;
                r = rq.pop_front();
                check("rv_side", d_rvalid, r.side);
                check("rv_beat", d_rvalid ? d_beat : i_beat, r.beat);
                check("rv_data", rdata, r.data);
                check("rv_other_beat", d_rvalid ? i_beat : d_beat, 0);
            end
        end
        if (i_done || d_done) begin
            check("done_both", i_done && d_done, 0);
            check("done_lat", cyc - last_ack_cyc, 1);
            if (dq.size() == 0) begin
                check("done_unexp", dq.size(), 1);
            end else begin
                check("done_side", d_done, dq.pop_front());
            end
        end
        if (mem_req) begin
            if (!prev_req) begin
                if (req_cyc >= 0) check("grant_lat", cyc - req_cyc, 1);
                if (exp_gap > 0) check("gap", locnt, exp_gap);
                req_cyc = -1;
                hicnt = 0;
            end
            hicnt = hicnt + 1;
        end else begin
            if (prev_req) begin
                if (chk_len) check("burst_len", hicnt, LW * (lat + 1));
                locnt = 0;
            end
            locnt = locnt + 1;
        end
        prev_req = mem_req;
    end

    task automatic push_burst(input logic side, input logic we,
                              input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~32'hF;
        for (int k = 0; k < LW; k++) begin
            mq.push_back('{we, base + 32'(4 * k),
                           we ? 32'hA0 + 32'(k) : 32'h0});
            if (!we) rq.push_back('{side, k, (base + 32'(4 * k)) ^ RKEY});
        end
        dq.push_back(side);
    endtask

    task automatic burst(input logic side, input logic we,
                         input logic [31:0] addr);
        push_burst(side, we, addr);
        @(negedge clk);
        if (side) begin
            d_addr = addr;
            d_we = we;
            d_req = 1'b1;
        end else begin
            i_addr = addr;
            i_req = 1'b1;
        end
        req_cyc = cyc;
        @(negedge clk);
        i_addr = 32'hFFFF_FF00;
        d_addr = 32'hFFFF_FF00;
        d_we = ~d_we;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #3;
            if (side ? d_done : i_done) break;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        check("burst_end", dq.size(), 0);
    endtask

    initial begin
        int ni;
        int nd;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_i_done", i_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        check("rst_beats", {i_beat, d_beat}, 0);
        check("rst_perf", {perf_grants_i, perf_grants_d, perf_wait}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // tie right after reset: I, D, I, D with a 2-cycle gap
        lat = 0;
        push_burst(1'b0, 1'b0, 32'h100);
        push_burst(1'b1, 1'b0, 32'h200);
        push_burst(1'b0, 1'b0, 32'h100);
        push_burst(1'b1, 1'b0, 32'h200);
        @(negedge clk);
        i_addr = 32'h100;
        d_addr = 32'h200;
        d_we = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        req_cyc = cyc;
        ni = 0;
        nd = 0;
        for (int n = 0; n < 300 && (ni < 2 || nd < 2); n++) begin
            @(negedge clk);
            #3;
            if (mem_req) exp_gap = 2;
            if (i_done) ni++;
            if (d_done) nd++;
            if (ni == 2) i_req = 1'b0;
            if (nd == 2) d_req = 1'b0;
        end
        exp_gap = 0;
        check("tie_bursts", dq.size(), 0);
`ifdef MEM_PORT_ARBITER_PERF_EN
        check("perf_gi", perf_grants_i, 2);
        check("perf_gd", perf_grants_d, 2);
`else
        check("perf_off", {perf_grants_i, perf_grants_d, perf_wait}, 0);
`endif

        lat = 2;
        burst(1'b0, 1'b0, 32'h1004);
        burst(1'b1, 1'b1, 32'h2000);

        lat = 0;
        burst(1'b0, 1'b0, 32'h40);
        @(negedge clk);
        #3;
        spur = 1'b1;
        @(negedge clk);
        #3;
        spur = 1'b0;
        check("spur_req", mem_req, 0);
        @(negedge clk);
        #3;
        check("spur_req2", mem_req, 0);

        // reset during beat 2 of a D read, d_req held across it
        lat = 1;
        chk_len = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mq.push_back('{1'b0, 32'h3000 + 32'(4 * k), 32'h0});
            rq.push_back('{1'b1, k, (32'h3000 + 32'(4 * k)) ^ RKEY});
        end
        push_burst(1'b1, 1'b0, 32'h3000);
        @(negedge clk);
        d_addr = 32'h3000;
        d_we = 1'b0;
        d_req = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #3;
            if (mem_req && d_beat == 2) break;
        end
        check("rst_reach_b2", d_beat, 2);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_done", d_done, 0);
        check("mid_rst_beat", d_beat, 0);
        check("mid_rst_perf", {perf_grants_i, perf_grants_d, perf_wait}, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #3;
            if (d_done) break;
        end
        d_req = 1'b0;
        check("regrant_done", dq.size(), 0);
        chk_len = 1'b1;

        repeat (3) @(negedge clk);
        check("mq_left", mq.size(), 0);
        check("rq_left", rq.size(), 0);
        check("dq_left", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
